// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and counter-width helper for the I2S receiver
package i2s_pkg;

    localparam int FMT_I2S = 0;
    localparam int FMT_LJ  = 1;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - bit-clock divider, sclk rise/fall strobes, slot bit counter and word select
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int SLOT_WIDTH = 32,
    parameter int CLK_DIV    = 2,
    parameter int BW         = cnt_w(SLOT_WIDTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic          sclk_o,
    output logic          wsel_o,
    output logic          rise_o,
    output logic [BW-1:0] bit_cnt_o
);

    localparam int DW = cnt_w(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_WIDTH - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          sclk_q, sclk_d;
    logic          wsel_q, wsel_d;
    logic          tick;
    logic          fall;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        rise_o    = en_i && !rst_i && tick && !sclk_q;
        fall      = en_i && !rst_i && tick && sclk_q;
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        sclk_d    = sclk_q ^ tick;
        bit_cnt_d = bit_cnt_q;
        wsel_d    = wsel_q;
        // The slot boundary sits on the fall after the last bit, so wsel changes with sclk low.
        if (fall) begin
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d = '0;
                wsel_d    = ~wsel_q;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            wsel_q    <= CH_LEFT;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            wsel_q    <= wsel_d;
        end
    end

    assign sclk_o    = sclk_q;
    assign wsel_o    = wsel_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/i2s_rx_master.sv
// rtl/i2s_rx_master.sv - I2S / left-justified master receiver, one parallel word per slot
// Optional ready/overrun handshake on the output when I2S_RX_HANDSHAKE_EN is defined.
module i2s_rx_master
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int CLK_DIV    = 2,
    parameter int FORMAT     = FMT_I2S
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  sdat_i,
`ifdef I2S_RX_HANDSHAKE_EN
    input  logic                  ready_i,
    output logic                  overrun_o,
`endif
    output logic                  sclk_o,
    output logic                  wsel_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  lr_chnl_o,
    output logic                  write_o
);

    localparam int BW    = cnt_w(SLOT_WIDTH);
    localparam int DELAY = (FORMAT == FMT_I2S) ? 1 : 0;
    localparam logic [BW-1:0] LAST_BIT = BW'(DELAY + DATA_WIDTH - 1);

    if (DATA_WIDTH + DELAY > SLOT_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH plus format delay exceeds SLOT_WIDTH");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end

    logic                  rise;
    logic [BW-1:0]         bit_cnt;
    logic                  in_win, capture, done;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  lr_q, lr_d;
    logic                  write_q, write_d;
`ifdef I2S_RX_HANDSHAKE_EN
    logic                  ovr_q, ovr_d;
`endif

    i2s_clk_gen #(
        .SLOT_WIDTH(SLOT_WIDTH),
        .CLK_DIV   (CLK_DIV),
        .BW        (BW)
    ) u_clk_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .sclk_o   (sclk_o),
        .wsel_o   (wsel_o),
        .rise_o   (rise),
        .bit_cnt_o(bit_cnt)
    );

    always_comb begin
        in_win  = (bit_cnt <= LAST_BIT) && (FORMAT == FMT_LJ || bit_cnt != '0);
        capture = rise && in_win;
        done    = capture && (bit_cnt == LAST_BIT);
        word    = DATA_WIDTH'({shift_q, sdat_i});
        shift_d = capture ? word : shift_q;
        data_d  = data_q;
        lr_d    = lr_q;
`ifdef I2S_RX_HANDSHAKE_EN
        write_d = write_q && !ready_i;
        ovr_d   = ovr_q;
        // A word finishing while the previous one is still unaccepted is lost.
        if (done) begin
            if (write_q && !ready_i) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = word;
                lr_d    = wsel_o;
                write_d = 1'b1;
            end
        end
`else
        write_d = done;
        if (done) begin
            data_d = word;
            lr_d   = wsel_o;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            data_q  <= '0;
            lr_q    <= CH_LEFT;
            write_q <= 1'b0;
`ifdef I2S_RX_HANDSHAKE_EN
            ovr_q   <= 1'b0;
`endif
        end else if (!en_i) begin
            shift_q <= '0;
            write_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            data_q  <= data_d;
            lr_q    <= lr_d;
            write_q <= write_d;
`ifdef I2S_RX_HANDSHAKE_EN
            ovr_q   <= ovr_d;
`endif
        end
    end

    assign data_o    = data_q;
    assign lr_chnl_o = lr_q;
    assign write_o   = write_q;
`ifdef I2S_RX_HANDSHAKE_EN
    assign overrun_o = ovr_q;
`endif

endmodule

// File: tb/tb_i2s_rx_master.sv
// tb/tb_i2s_rx_master.sv - scoreboard bench for i2s_rx_master across formats and dividers
module tb_i2s_rx_master;

    localparam int NI = 3;
    localparam int DIVS [NI] = '{2, 1, 3};
    localparam int FMTS [NI] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0] en = '0;
    logic [NI-1:0] sdat, sclk, wsel, lr, wr;
`ifdef I2S_RX_HANDSHAKE_EN
    logic [NI-1:0] rdy = '1;
    logic [NI-1:0] ovr;
`endif
    logic [15:0] dat [NI];
    logic [15:0] lw  [NI];
    logic [15:0] rw  [NI];
    logic [16:0] exp_q [NI][$];
    int en_cyc [NI];
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, expv);
        end
    endtask

    // Codec model: slot position p counts sclk falls since enable; data shifts out MSB first.
    function automatic logic tx_bit(input int p, input int fmt, input logic [15:0] l, input logic [15:0] r);
        int sp;
        int bi;
        logic [15:0] w;
        sp = p % 32;
        bi = sp - ((fmt == 0) ? 1 : 0);
        w  = (((p / 32) % 2) == 1) ? r : l;
        if (bi >= 0 && bi < 16) return w[15-bi];
        return 1'b1;
    endfunction

    for (genvar i = 0; i < NI; i++) begin : g_dut
        int pos = 0;
        int last_rise = 0;
        int left_cyc = 0;
        bit have_rise = 0;
        bit have_left = 0;
        logic prev_wsel = 1'b0;
        logic fire;
        logic [16:0] e;

        i2s_rx_master #(
            .DATA_WIDTH(16),
            .SLOT_WIDTH(32),
            .CLK_DIV   (DIVS[i]),
            .FORMAT    (FMTS[i])
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst),
            .en_i     (en[i]),
            .sdat_i   (sdat[i]),
`ifdef I2S_RX_HANDSHAKE_EN
            .ready_i  (rdy[i]),
            .overrun_o(ovr[i]),
`endif
            .sclk_o   (sclk[i]),
            .wsel_o   (wsel[i]),
            .data_o   (dat[i]),
            .lr_chnl_o(lr[i]),
            .write_o  (wr[i])
        );

        assign sdat[i] = tx_bit(pos, FMTS[i], lw[i], rw[i]);
`ifdef I2S_RX_HANDSHAKE_EN
        assign fire = wr[i] && rdy[i];
`else
        assign fire = wr[i];
`endif

        always @(negedge sclk[i] or negedge en[i] or posedge rst) begin
            if (!en[i] || rst) pos = 0;
            else pos++;
        end

        always @(posedge sclk[i]) begin
            if (!have_rise) chk("first_rise", i, cyc - en_cyc[i], DIVS[i]);
            else chk("sclk_period", i, cyc - last_rise, 2 * DIVS[i]);
            have_rise = 1;
            last_rise = cyc;
        end

        always @(negedge clk) begin
            if (rst || !en[i]) begin
                have_rise = 0;
                have_left = 0;
            end else if (wsel[i] != prev_wsel) begin
                chk("wsel_toggle", i, {30'd0, (pos % 32) == 0, pos > 0}, 32'd3);
            end
            prev_wsel = wsel[i];
            if (!rst && fire) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write[%0d]: got lr=%0d data=%0h expected no write", i, lr[i], dat[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    chk("word", i, {15'd0, lr[i], dat[i]}, {15'd0, e});
                    if (lr[i] && have_left) chk("lr_spacing", i, cyc - left_cyc, 64 * DIVS[i]);
                    if (!lr[i]) begin
                        have_left = 1;
                        left_cyc  = cyc;
                    end
                end
            end
        end
    end

    task automatic start(input logic [NI-1:0] mask);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                en[i]     = 1'b1;
                en_cyc[i] = cyc;
            end
        end
    endtask

    task automatic run(input logic [NI-1:0] mask);
        logic [NI-1:0] busy;
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                exp_q[i].push_back({1'b0, lw[i]});
                exp_q[i].push_back({1'b1, rw[i]});
            end
        end
        start(mask);
        busy = mask;
        for (int t = 0; t < 2000 && busy != '0; t++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (busy[i] && exp_q[i].size() == 0) begin
                    en[i]   = 1'b0;
                    busy[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (busy[i]) begin
                checks++;
                errors++;
                $display("FAIL timeout[%0d]: got %0d words outstanding expected 0", i, exp_q[i].size());
                exp_q[i].delete();
                en[i] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < NI; i++) begin
            chk("rst_sclk", i, {31'd0, sclk[i]}, 0);
            chk("rst_wsel", i, {31'd0, wsel[i]}, 0);
            chk("rst_write", i, {31'd0, wr[i]}, 0);
            chk("rst_data", i, {16'd0, dat[i]}, 0);
            chk("rst_lr", i, {31'd0, lr[i]}, 0);
`ifdef I2S_RX_HANDSHAKE_EN
            chk("rst_overrun", i, {31'd0, ovr[i]}, 0);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            lw[i] = 16'h0;
            rw[i] = 16'h0;
            en_cyc[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1 rst = 1'b0;

        lw = '{16'hA5C3, 16'h8001, 16'hA5C3};
        rw = '{16'h3C5A, 16'hFFFE, 16'h3C5A};
        run(3'b111);
        lw = '{16'h8001, 16'hA5C3, 16'h0F0F};
        rw = '{16'hFFFE, 16'h3C5A, 16'hF0F0};
        run(3'b111);

        start(3'b111);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        en  = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        lw[0] = 16'h1234;
        rw[0] = 16'hBEEF;
        start(3'b001);
        repeat (36) @(posedge clk);
        #1 en[0] = 1'b0;
        repeat (4) @(posedge clk);
        run(3'b001);

`ifdef I2S_RX_HANDSHAKE_EN
        lw[0] = 16'hC0DE;
        rw[0] = 16'hDEAD;
        rdy[0] = 1'b0;
        exp_q[0].push_back({1'b0, 16'hC0DE});
        start(3'b001);
        repeat (130) @(posedge clk);
        @(negedge clk);
        chk("hs_held_write", 0, {31'd0, wr[0]}, 1);
        chk("hs_no_overrun_yet", 0, {31'd0, ovr[0]}, 0);
        repeat (130) @(posedge clk);
        @(negedge clk);
        chk("hs_still_held", 0, {15'd0, wr[0], dat[0]}, {15'd0, 1'b1, 16'hC0DE});
        chk("hs_lr_held", 0, {31'd0, lr[0]}, 0);
        chk("hs_overrun", 0, {31'd0, ovr[0]}, 1);
        @(posedge clk);
        #1 rdy[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 en[0] = 1'b0;
        chk("hs_accepted", 0, exp_q[0].size(), 0);
        @(negedge clk);
        chk("hs_overrun_sticky", 0, {31'd0, ovr[0]}, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hs_overrun_cleared", 0, {31'd0, ovr[0]}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        repeat (5) @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("leftover_expect", i, exp_q[i].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_master.md
Name: i2s_rx_master

Overview:
Parametrised I2S master receiver. It generates the bit clock (sclk_o) and word select (wsel_o) from clk_i and deserialises sdat_i into one parallel word per channel slot. Data width, slot width, bit-clock divider and frame format (Philips I2S or left-justified) are all configurable. It replaces the fixed 16-bit receiver and feeds the same parallel sink interface (data_o, lr_chnl_o, write_o).

Parameters:
DATA_WIDTH, 16, bits captured per channel word; MSB first.
SLOT_WIDTH, 32, sclk periods per channel slot (half frame).
CLK_DIV, 2, clk_i cycles per sclk half-period; must be >= 1.
FORMAT, 0, 0 = I2S (MSB one sclk after the wsel edge); 1 = left-justified (MSB on the wsel edge).

Ports:
clk_i  in  1  system clock; all logic on its rising edge
rst_i  in  1  synchronous reset, active high
en_i  in  1  run enable; low holds the block idle
sdat_i  in  1  serial data from the codec
sclk_o  out  1  generated bit clock
wsel_o  out  1  word select; 0 = left, 1 = right
data_o  out  DATA_WIDTH  last completed word
lr_chnl_o  out  1  channel of data_o; 0 = left, 1 = right
write_o  out  1  one-cycle strobe, data_o/lr_chnl_o valid

Behaviour:
- Reset (rst_i high at a clk_i edge): sclk_o=0, wsel_o=0, data_o=0, lr_chnl_o=0, write_o=0, all counters 0, shift register 0.
- Elaboration error if DATA_WIDTH + (FORMAT==0 ? 1 : 0) > SLOT_WIDTH, or if CLK_DIV < 1.
- Divider: div_cnt runs 0..CLK_DIV-1. At div_cnt==CLK_DIV-1, sclk_o toggles and div_cnt wraps to 0.
- Strobes: rise = the cycle in which sclk_o goes 0->1; fall = the cycle in which it goes 1->0. sclk period = 2*CLK_DIV clk_i cycles.
- bit_cnt runs 0..SLOT_WIDTH-1 and increments on each fall strobe. On the fall strobe at bit_cnt==SLOT_WIDTH-1, bit_cnt wraps to 0 and wsel_o toggles.
- Capture: on each rise strobe, sdat_i is shifted into the LSB of the shift register. A bit is captured only when bit_cnt is in [D, D+DATA_WIDTH-1], where D=1 for I2S and D=0 for left-justified. Bits outside that range are ignored.
- Completion: on the rise strobe that captures bit index D+DATA_WIDTH-1, at the next clk_i edge:
  - data_o <= complete word,
  - lr_chnl_o <= wsel_o of that slot,
  - write_o = 1 for exactly one cycle.
- data_o and lr_chnl_o hold until the next completion.
- Latency: write_o asserts one clk_i cycle after the rise strobe of the last data bit.
- en_i low: same state as reset except data_o and lr_chnl_o keep their values. A partial word is discarded and no write_o is issued.
- en_i rising: the frame starts at left slot, bit 0, with sclk_o=0. The first sclk rise occurs CLK_DIV cycles later.
- rst_i takes priority over en_i. Reset mid-word discards the word.

Optional Feature:
I2S_RX_HANDSHAKE_EN defined:
- Adds ready_i (in, 1) and overrun_o (out, 1).
- write_o becomes a valid signal: it stays high with data_o/lr_chnl_o stable until a cycle with write_o&&ready_i; it drops the following cycle unless a new word completes in that same cycle.
- A word completing while write_o is high and ready_i is low is dropped, and overrun_o goes high. overrun_o stays set until rst_i.
- Reset: overrun_o=0.
Undefined: neither port exists, and write_o is the single-cycle strobe described under Behaviour.

Decomposition:
- Shared package i2s_pkg: FMT_I2S=0, FMT_LJ=1, CH_LEFT=0, CH_RIGHT=1, and a clog2-based counter-width helper.
- One sub-module, i2s_clk_gen: divider, sclk_o, rise/fall strobes, bit_cnt, wsel_o.
- The top level holds the shift register, capture window and output/handshake logic.

Test Plan:
- Reset: assert rst_i for 3 cycles mid-frame -> one edge later sclk_o=0, wsel_o=0, write_o=0, data_o=16'h0000, lr_chnl_o=0.
- I2S defaults: bench transmitter drives left 16'hA5C3 and right 16'h3C5A on sclk falls, delayed by one bit -> write_o pulses with lr=0/A5C3, then lr=1/3C5A; the strobes are 128 clk_i cycles apart.
- FORMAT=1, left 16'h8001, right 16'hFFFE -> data_o 8001 (lr=0), then FFFE (lr=1); no bit slip.
- CLK_DIV=1 and CLK_DIV=3 -> sclk period 2 and 6 clk_i cycles; wsel_o toggles only on the fall after bit 31.
- Drop en_i at left bit 8, then restore it -> no write_o for the partial word; the next full left word 16'h1234 is received intact.
- With I2S_RX_HANDSHAKE_EN, hold ready_i=0 across two completions -> first word held, second dropped, overrun_o=1; raising ready_i accepts the first word.
